// File: rtl/adf4158_ramp_tracker.sv
// adf4158_ramp_tracker
// ---------------------------------------------------------------------------
// Purpose:
//   Companion to the ADF4158 configuration controller. It watches the chip's
//   MUXOUT digital-lock-detect pin and waits for the controller's config_done
//   pulse. Once the PLL lock is qualified, it regenerates the chip's sawtooth
//   ramp timing locally in the clk domain. It emits ramp-start markers and
//   evenly spaced sample strobes, each carrying its sample index within the
//   ramp, for the ADC capture and FFT framing stages.
//
// Ports:
//   clk          in   system clock; all logic runs on its rising edge
//   rst          in   synchronous, active-high reset
//   enable       in   tracker enable (level); low forces IDLE on the next edge
//   config_done  in   configuration complete (clk-synchronous); rising edge used
//   muxout       in   ADF4158 MUXOUT lock detect (asynchronous)
//   locked       out  filtered lock indication
//   lock_err     out  sticky: lock was lost while ramping
//   ramp_active  out  high while in RUN
//   ramp_start   out  one-cycle pulse on the first cycle of every ramp
//   ramp_count   out  number of ramps started (wraps at 2^16)
//   sample_valid out  one-cycle sample strobe
//   sample_idx   out  0-based sample index within the ramp, valid with strobe
// ---------------------------------------------------------------------------
module adf4158_ramp_tracker #(
  parameter int LOCK_FILTER_CYCLES = 64,
  parameter int RAMP_CYCLES        = 40000,
  parameter int SETTLE_CYCLES      = 400,
  parameter int SAMPLE_DIV         = 20,
  parameter int IDX_W              = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             config_done,
  input  logic             muxout,
  output logic             locked,
  output logic             lock_err,
  output logic             ramp_active,
  output logic             ramp_start,
  output logic [15:0]      ramp_count,
  output logic             sample_valid,
  output logic [IDX_W-1:0] sample_idx
);

  localparam int CTR_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int LF_W  = $clog2(LOCK_FILTER_CYCLES + 1);

  localparam logic [CTR_W-1:0] RAMP_LAST = CTR_W'(RAMP_CYCLES - 1);
  localparam logic [CTR_W-1:0] SETTLE_AT = CTR_W'(SETTLE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [LF_W-1:0]  LF_MAX    = LF_W'(LOCK_FILTER_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    WAIT_LOCK = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // MUXOUT synchronizer and lock filter (runs in every state)
  // ---------------------------------------------------------------------------
  logic            sync1_q, sync2_q;
  logic [LF_W-1:0] lf_cnt_q, lf_cnt_d;
  logic            locked_q;

  always_comb begin
    lf_cnt_d = lf_cnt_q;
    if (!sync2_q) begin
      lf_cnt_d = '0;
    end else if (lf_cnt_q != LF_MAX) begin
      lf_cnt_d = lf_cnt_q + LF_W'(1);
    end
  end

  // locked is registered alongside the counter (compare on the next value),
  // so pin-to-locked is 2 sync stages + LOCK_FILTER_CYCLES, and a synchronized
  // low drops locked on the very next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      lf_cnt_q <= '0;
      locked_q <= 1'b0;
    end else begin
      sync1_q  <= muxout;
      sync2_q  <= sync1_q;
      lf_cnt_q <= lf_cnt_d;
      locked_q <= (lf_cnt_d == LF_MAX);
    end
  end

  // ---------------------------------------------------------------------------
  // config_done rising-edge detect
  // ---------------------------------------------------------------------------
  logic cfg_prev_q;
  logic cfg_rise;

  assign cfg_rise = config_done & ~cfg_prev_q;

  // ---------------------------------------------------------------------------
  // Ramp FSM and timing counters
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      count_q, count_d;
  logic             lock_err_q, lock_err_d;
  logic             past_settle;
  logic             sample_hit;

  assign past_settle = (ctr_q >= SETTLE_AT);
  // The divider sits at zero through the settle window, so the first strobe
  // lands exactly on SETTLE_CYCLES and then every SAMPLE_DIV cycles.
  assign sample_hit  = (state_q == RUN) && past_settle && (div_q == '0);

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    div_d      = div_q;
    idx_d      = idx_q;
    count_d    = count_q;
    lock_err_d = lock_err_q;

    if (!enable) begin
      // Disable wins over cfg_rise, lock changes and ramp wrap.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          lock_err_d = 1'b0;
          if (cfg_rise) begin
            state_d = WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (locked_q) begin
            state_d = RUN;
            ctr_d   = '0;
            div_d   = '0;
            idx_d   = '0;
            count_d = count_q + 16'd1;
          end
        end
        RUN: begin
          if (!locked_q) begin
            state_d    = LOST;
            lock_err_d = 1'b1;
          end else if (ctr_q == RAMP_LAST) begin
            ctr_d   = '0;
            div_d   = '0;
            idx_d   = '0;
            count_d = count_q + 16'd1;
          end else begin
            ctr_d = ctr_q + CTR_W'(1);
            if (past_settle) begin
              div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
              if (div_q == '0) begin
                idx_d = idx_q + IDX_W'(1);
              end
            end
          end
        end
        LOST: begin
          state_d = LOST;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      lock_err_q <= 1'b0;
      cfg_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      lock_err_q <= lock_err_d;
      cfg_prev_q <= config_done;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so leaving RUN (or reset)
  // removes every ramp output on the following edge.
  // ---------------------------------------------------------------------------
  assign locked       = locked_q;
  assign lock_err     = lock_err_q;
  assign ramp_active  = (state_q == RUN);
  assign ramp_start   = (state_q == RUN) && (ctr_q == '0);
  assign ramp_count   = count_q;
  assign sample_valid = sample_hit;
  assign sample_idx   = idx_q;

endmodule
